native_mem_arbiter: RTL and testbench

- Two-master arbiter sharing one memory/peripheral port using the native valid/ready memory handshake (valid, instr, addr, wdata, wstrb, ready, rdata).
- m0 is typically the CPU core; m1 is a second requester (loader, DMA, debug).
- Round-robin grant with one-cycle arbitration latency, whole-transaction ownership, and a per-transaction timeout that frees the bus when the slave never responds.

---
 rtl/native_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_native_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_arbiter.sv
// native_mem_arbiter: two-master round-robin arbiter in front of one native valid/ready
// memory port. A granted master keeps the bus for its whole transaction; a timeout frees a hung slave.
module native_mem_arbiter #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  // The wait counter only has to reach TIMEOUT-1, so it is sized for that value.
  localparam int               CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit               TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state, state_next;
  logic [1:0]       grant_next;
  logic             last, last_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             timeout_err_next;

  logic             owner_valid;
  logic             done;
  logic [31:0]      done_rdata;

  always_comb begin
    owner_valid = m0_valid;
    s_instr     = m0_instr;
    s_addr      = m0_addr;
    s_wdata     = m0_wdata;
    s_wstrb     = m0_wstrb;
    if (grant[1]) begin
      owner_valid = m1_valid;
      s_instr     = m1_instr;
      s_addr      = m1_addr;
      s_wdata     = m1_wdata;
      s_wstrb     = m1_wstrb;
    end
  end

  assign s_valid = (state == BUSY);

  // last holds the index of the master that most recently completed (0 = m0, 1 = m1).
  always_comb begin
    state_next       = state;
    grant_next       = grant;
    last_next        = last;
    wait_cnt_next    = wait_cnt;
    timeout_err_next = 1'b0;
    done             = 1'b0;
    done_rdata       = '0;

    case (state)
      IDLE: begin
        grant_next = 2'b00;
        if (m0_valid || m1_valid) begin
          state_next    = BUSY;
          wait_cnt_next = '0;
          if (m0_valid && m1_valid) begin
            grant_next = last ? 2'b01 : 2'b10;
          end else if (m0_valid) begin
            grant_next = 2'b01;
          end else begin
            grant_next = 2'b10;
          end
        end
      end

      BUSY: begin
        // An owner abandoning its request silently releases the bus.
        if (!owner_valid) begin
          state_next = IDLE;
          grant_next = 2'b00;
        end else if (s_ready) begin
          done       = 1'b1;
          done_rdata = s_rdata;
          last_next  = grant[1];
          state_next = IDLE;
          grant_next = 2'b00;
        end else if (TIMEOUT_EN && (wait_cnt == CNT_MAX)) begin
          done             = 1'b1;
          done_rdata       = ERR_RDATA;
          timeout_err_next = 1'b1;
          last_next        = grant[1];
          state_next       = IDLE;
          grant_next       = 2'b00;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      last        <= last_next;
      wait_cnt    <= wait_cnt_next;
      timeout_err <= timeout_err_next;
    end
  end

  assign m0_ready = done && grant[0];
  assign m1_ready = done && grant[1];
  assign m0_rdata = (done && grant[0]) ? done_rdata : 32'h0;
  assign m1_rdata = (done && grant[1]) ? done_rdata : 32'h0;

endmodule

// File: tb/tb_native_mem_arbiter.sv
// tb_native_mem_arbiter: scoreboard bench for native_mem_arbiter with master drivers,
// an address-keyed slave model and a monitor that checks every ready pulse.
module tb_native_mem_arbiter;

  localparam int          TO        = 8;
  localparam logic [31:0] ERR       = 32'hdead_beef;
  localparam logic [31:0] KEY       = 32'h1235_5678;
  localparam logic [31:0] HANG_ADDR = 32'hbad0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic [1:0]  mv = 2'b00;
  logic [1:0]  minstr = 2'b00;
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];
  logic [3:0]  mwstrb [2];

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  grant;
  logic        timeout_err;

  native_mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (mv[0]),
    .m0_instr   (minstr[0]),
    .m0_addr    (maddr[0]),
    .m0_wdata   (mwdata[0]),
    .m0_wstrb   (mwstrb[0]),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (mv[1]),
    .m1_instr   (minstr[1]),
    .m1_addr    (maddr[1]),
    .m1_wdata   (mwdata[1]),
    .m1_wstrb   (mwstrb[1]),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_instr    (s_instr),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          drop_after;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          order;
    int          busy_len;
  } exp_t;

  req_t req_q [2][$];
  exp_t exp_q [2][$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   slave_delay = 2;
  int   sv_cnt = 0;
  int   rdy_cyc [16];
  logic done [2];
  int   held [2];
  logic flush = 1'b0;
  logic mon_en = 1'b0;

  task automatic check_output(input string name, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Master drivers: present the queue head, hold it until the monitor reports ready.
  always @(posedge clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      if (flush) begin
        req_q[m].delete();
        mv[m]   = 1'b0;
        done[m] = 1'b0;
        held[m] = 0;
      end else begin
        if (done[m]) begin
          done[m] = 1'b0;
          if (req_q[m].size() > 0) req_q[m].delete(0);
          held[m] = 0;
        end else if (mv[m] && req_q[m].size() > 0 && req_q[m][0].drop_after > 0 &&
                     held[m] == req_q[m][0].drop_after) begin
          req_q[m].delete(0);
          held[m] = 0;
          mv[m]   = 1'b0;
          continue;
        end
        if (req_q[m].size() > 0) begin
          mv[m]     = 1'b1;
          minstr[m] = req_q[m][0].instr;
          maddr[m]  = req_q[m][0].addr;
          mwdata[m] = req_q[m][0].wdata;
          mwstrb[m] = req_q[m][0].wstrb;
          held[m]++;
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
    flush = 1'b0;
  end

  // Slave: answers on the slave_delay-th s_valid cycle with addr^KEY, never for HANG_ADDR.
  always @(posedge clk) begin
    #3;
    if (s_valid) sv_cnt = sv_cnt + 1;
    else sv_cnt = 0;
    if (s_valid && s_addr != HANG_ADDR && sv_cnt == slave_delay) begin
      s_ready = 1'b1;
      s_rdata = s_addr ^ KEY;
    end else begin
      s_ready = 1'b0;
      s_rdata = 32'h0;
    end
  end

  // Monitor: scoreboard pops on every ready pulse, plus forwarding and error-pulse checks.
  always @(negedge clk) begin : monitor
    int   own;
    int   busy_run;
    int   comp_idx;
    logic terr_exp;
    logic terr_pending;
    logic [1:0] rdy;
    exp_t e;
    if (mon_en) begin
      if (s_valid) busy_run++;
      else busy_run = 0;

      if (s_valid) begin
        own = (grant == 2'b10) ? 1 : 0;
        if (mv[own] && req_q[own].size() > 0)
          check_output("forward", {3'b0, s_instr, s_addr, s_wdata, s_wstrb},
                       {3'b0, req_q[own][0].instr, req_q[own][0].addr, req_q[own][0].wdata, req_q[own][0].wstrb});
      end

      check_output("timeout_err", timeout_err, terr_pending ? terr_exp : 1'b0);
      terr_pending = 1'b0;

      rdy = {m1_ready, m0_ready};
      if (rdy == 2'b11) check_output("ready_onehot", rdy, 2'b01);
      for (int m = 0; m < 2; m++) begin
        if (rdy[m]) begin
          done[m] = 1'b1;
          if (exp_q[m].size() == 0) begin
            check_output(m ? "m1_unexpected_ready" : "m0_unexpected_ready", 1'b1, 1'b0);
          end else begin
            e = exp_q[m].pop_front();
            check_output(m ? "m1_rdata" : "m0_rdata", m ? m1_rdata : m0_rdata, e.rdata);
            check_output(m ? "m0_rdata_idle" : "m1_rdata_idle", m ? m0_rdata : m1_rdata, 32'h0);
            check_output("order", comp_idx, e.order);
            check_output("busy_len", busy_run, e.busy_len);
            check_output("grant_at_ready", grant, m ? 2'b10 : 2'b01);
            if (e.order >= 0 && e.order < 16) rdy_cyc[e.order] = cyc;
            terr_exp     = e.err;
            terr_pending = 1'b1;
            comp_idx++;
          end
        end
      end
    end else begin
      busy_run     = 0;
      comp_idx     = 0;
      terr_exp     = 1'b0;
      terr_pending = 1'b0;
    end
  end

  task automatic apply_stimulus(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic instr, input logic [31:0] exp_rdata,
                                input logic exp_err, input int order, input int busy_len,
                                input bit expect_resp, input int drop_after);
    req_t r;
    exp_t e;
    r.instr      = instr;
    r.addr       = addr;
    r.wdata      = wdata;
    r.wstrb      = wstrb;
    r.drop_after = drop_after;
    req_q[m].push_back(r);
    if (expect_resp) begin
      e.rdata    = exp_rdata;
      e.err      = exp_err;
      e.order    = order;
      e.busy_len = busy_len;
      exp_q[m].push_back(e);
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((req_q[0].size() + req_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 || s_valid) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check_output("quiet_timeout", 1'b1, 1'b0);
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) rdy_cyc[i] = 0;
    for (int m = 0; m < 2; m++) begin
      done[m] = 1'b0; held[m] = 0;
      maddr[m] = '0; mwdata[m] = '0; mwstrb[m] = '0;
    end

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    check_output("rst_s_valid", s_valid, 1'b0);
    check_output("rst_grant", grant, 2'b00);
    check_output("rst_m0_ready", m0_ready, 1'b0);
    check_output("rst_m1_ready", m1_ready, 1'b0);
    check_output("rst_m0_rdata", m0_rdata, 32'h0);
    check_output("rst_m1_rdata", m1_rdata, 32'h0);
    check_output("rst_timeout_err", timeout_err, 1'b0);
    @(posedge clk); #2;
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] m0 single read");
    slave_delay = 3;
    apply_stimulus(0, 32'h0001_0000, 32'h0, 4'b0000, 1'b0, 32'h1234_5678, 1'b0, 0, 3, 1'b1, 0);
    @(negedge clk);
    check_output("req_cycle_s_valid", s_valid, 1'b0);
    @(negedge clk);
    check_output("next_cycle_s_valid", s_valid, 1'b1);
    check_output("next_cycle_grant", grant, 2'b01);
    wait_quiet();

    $display("[TB] m1 byte write");
    apply_stimulus(1, 32'h1000_0000, 32'h0000_00ab, 4'b0001, 1'b0, 32'h0235_5678, 1'b0, 1, 3, 1'b1, 0);
    wait_quiet();

    $display("[TB] alternating contention");
    slave_delay = 2;
    apply_stimulus(0, 32'h0000_0010, 32'h0, 4'b0000, 1'b1, 32'h1235_5668, 1'b0, 2, 2, 1'b1, 0);
    apply_stimulus(0, 32'h0000_0020, 32'h0, 4'b0000, 1'b1, 32'h1235_5658, 1'b0, 4, 2, 1'b1, 0);
    apply_stimulus(0, 32'h0000_0030, 32'h0, 4'b0000, 1'b1, 32'h1235_5648, 1'b0, 6, 2, 1'b1, 0);
    apply_stimulus(1, 32'h0000_1000, 32'h5555_0001, 4'b1111, 1'b0, 32'h1235_4678, 1'b0, 3, 2, 1'b1, 0);
    apply_stimulus(1, 32'h0000_2000, 32'h5555_0002, 4'b1100, 1'b0, 32'h1235_7678, 1'b0, 5, 2, 1'b1, 0);
    apply_stimulus(1, 32'h0000_3000, 32'h5555_0003, 4'b0000, 1'b0, 32'h1235_6678, 1'b0, 7, 2, 1'b1, 0);
    wait_quiet();
    for (int k = 2; k < 7; k++) check_output("rr_spacing", rdy_cyc[k+1] - rdy_cyc[k], 3);

    $display("[TB] timeout then pending m1");
    apply_stimulus(0, HANG_ADDR, 32'h0, 4'b0000, 1'b0, ERR, 1'b1, 8, 8, 1'b1, 0);
    apply_stimulus(1, 32'h2000_0040, 32'h0, 4'b0000, 1'b0, 32'h3235_5638, 1'b0, 9, 2, 1'b1, 0);
    wait_quiet();
    check_output("after_timeout_spacing", rdy_cyc[9] - rdy_cyc[8], 3);

    $display("[TB] ready on last allowed cycle");
    slave_delay = 8;
    apply_stimulus(0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0, 32'h1235_5778, 1'b0, 10, 8, 1'b1, 0);
    wait_quiet();

    $display("[TB] owner drops valid");
    slave_delay = 2;
    apply_stimulus(1, HANG_ADDR, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0, 3);
    wait_quiet();
    apply_stimulus(0, 32'h0000_0008, 32'h0, 4'b0000, 1'b0, 32'h1235_5670, 1'b0, 12, 2, 1'b1, 0);
    apply_stimulus(1, 32'h0000_0004, 32'h0, 4'b0000, 1'b0, 32'h1235_567c, 1'b0, 11, 2, 1'b1, 0);
    wait_quiet();

    $display("[TB] reset mid-transaction");
    apply_stimulus(0, HANG_ADDR, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_output("pre_reset_s_valid", s_valid, 1'b1);
    @(posedge clk); #2;
    resetn = 1'b0;
    flush  = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(negedge clk);
    check_output("mid_reset_s_valid", s_valid, 1'b0);
    check_output("mid_reset_grant", grant, 2'b00);
    check_output("mid_reset_m0_ready", m0_ready, 1'b0);
    apply_stimulus(0, 32'h0000_0200, 32'h0, 4'b0000, 1'b0, 32'h1235_5478, 1'b0, 13, 2, 1'b1, 0);
    apply_stimulus(1, 32'h0000_0300, 32'h0, 4'b0000, 1'b0, 32'h1235_5578, 1'b0, 14, 2, 1'b1, 0);
    wait_quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
